// File: rtl/ulpi_reg_ctrl.sv
// ULPI register-access sequencer for the USB3300 PHY.
// Runs one immediate-address register read or write per request on the shared
// 8-bit ULPI bus (TXCMD / data / STP). It gives the bus to the PHY whenever DIR
// is high, and it retries accesses that the PHY aborts.
//
// Handshake: a request is accepted on a rising clk edge where req=1 and busy=0.
// busy stays high until the cycle that carries the done or err pulse. Requests
// made while busy=1 are dropped and are not queued. On the ULPI side the PHY
// accepts a driven byte on each edge where nxt=1 and dir=0.
module ulpi_reg_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic       we,
  input  logic [5:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] rdata,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic       dir,
  input  logic       nxt,
  output logic       stp,
  output logic [3:0] dbg_state
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);
  localparam logic [7:0]    TLIM = 8'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_WDATA, S_WSTP, S_RTURN1, S_RDATA, S_RTURN2, S_ABORT, S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic          we_q, we_d;
  logic [5:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    data_o_q, data_o_d;
  logic          oe_q, oe_d;
  logic          stp_q, stp_d;
  logic          timed_out;

  assign timed_out = (tcnt_q == TLIM);

  // Next-state logic. All outputs are derived from the next state so that they
  // can be registered.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    retry_d = retry_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      // FIN behaves like IDLE because busy is already low during the done cycle.
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (pend_q) begin
          if (!dir) begin
            pend_d  = 1'b0;
            state_d = S_CMD;
          end
        end else if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          retry_d = '0;
          if (!dir) state_d = S_CMD;
          else      pend_d  = 1'b1;
        end
      end
      S_CMD: begin
        if (dir)            state_d = S_ABORT;
        else if (nxt)       state_d = we_q ? S_WDATA : S_RTURN1;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WDATA: begin
        if (dir)            state_d = S_ABORT;
        else if (nxt)       state_d = S_WSTP;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WSTP: state_d = S_FIN;
      S_RTURN1: begin
        if (dir)            state_d = S_RDATA;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      // A turnaround with nxt high means an RX packet is coming in. A dropped
      // dir also loses the data. In both cases the attempt is retried.
      S_RDATA: begin
        if (dir && !nxt) begin
          rdata_d = data_i;
          state_d = S_RTURN2;
        end else begin
          state_d = S_ABORT;
        end
      end
      S_RTURN2: begin
        if (!dir)           state_d = S_FIN;
        else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_ABORT: begin
        if (!dir) begin
          if (retry_q < RMAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_CMD;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The wait counter restarts on every state entry.
    if ((state_d != state_q) || (state_q == S_IDLE) || (state_q == S_FIN))
      tcnt_d = 8'd0;
    else
      tcnt_d = tcnt_q + 8'd1;

    busy_d = pend_d || !((state_d == S_IDLE) || (state_d == S_FIN));
    done_d = (state_d == S_FIN);
    oe_d   = (state_d == S_CMD) || (state_d == S_WDATA) || (state_d == S_WSTP);
    stp_d  = (state_d == S_WSTP);

    case (state_d)
      S_CMD:   data_o_d = {1'b1, ~we_d, addr_d};
      S_WDATA: data_o_d = wdata_d;
      default: data_o_d = 8'h00;
    endcase
  end

  // State and output registers. Reset abandons any access without sending STP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 6'd0;
      wdata_q  <= 8'h00;
      retry_q  <= '0;
      tcnt_q   <= 8'd0;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      data_o_q <= 8'h00;
      oe_q     <= 1'b0;
      stp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      retry_q  <= retry_d;
      tcnt_q   <= tcnt_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      data_o_q <= data_o_d;
      oe_q     <= oe_d;
      stp_q    <= stp_d;
    end
  end

  // dir gates the pad enable directly, so the link never drives against the PHY.
  assign data_oe   = oe_q & ~dir;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign data_o    = data_o_q;
  assign stp       = stp_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// Bench for ulpi_reg_ctrl. A reactive PHY model answers on the ULPI bus. A
// transaction-level reference predicts the bus bytes, the outcome, the latency
// and the read data of each access.
module tb_ulpi_reg_ctrl;

  localparam int TIMEOUT   = 16;
  localparam int MAX_RETRY = 3;

  localparam int PH_IDLE  = 0;
  localparam int PH_WDATA = 1;
  localparam int PH_STP   = 2;
  localparam int PH_RTURN = 3;
  localparam int PH_RDATA = 4;
  localparam int PH_RREL  = 5;
  localparam int PH_HOLD  = 6;
  localparam int PH_FIN   = 7;

  logic       clk = 1'b0;
  logic       rstn;
  logic       req;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic       busy, done, err;
  logic [7:0] rdata;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       data_oe;
  logic       dir, nxt, stp;
  logic [3:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] ref_reg [64];
  logic [7:0] phy_reg [64];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];

  ulpi_reg_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rstn(rstn), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .data_i(data_i),
    .data_o(data_o), .data_oe(data_oe), .dir(dir), .nxt(nxt), .stp(stp),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_err"}, err, 0);
    check_val({tag, "_rdata"}, rdata, 8'h00);
    check_val({tag, "_data_o"}, data_o, 8'h00);
    check_val({tag, "_data_oe"}, data_oe, 0);
    check_val({tag, "_stp"}, stp, 0);
  endtask

  // One access. cmd_dly/dat_dly are the NXT wait cycles. A cmd_dly of TIMEOUT or
  // more means the PHY never answers. n_abort is the number of TXCMDs the PHY
  // aborts with DIR. pre_dir is the number of cycles DIR is already high when req
  // arrives. rst_at is the cycle at which rstn is pulled low, or -1 for none.
  task automatic run_access(input bit a_we, input logic [5:0] a_addr, input logic [7:0] a_wdata,
                            input int cmd_dly, input int dat_dly, input int n_abort,
                            input int pre_dir, input bit noise, input int rst_at);
    int ph, hold, wait_cnt, cyc, end_cyc, busy_low, stray_stp, contention, aborts_left;
    bit cmd_seen, dat_seen, ended, got_done, got_err, timeout_case, exp_err;
    int n_cmd, exp_end;
    logic [5:0] seen_addr;
    logic [7:0] seen_w, exp_cmd;
    bit seen_we;

    timeout_case = (cmd_dly >= TIMEOUT);
    exp_err = timeout_case || (n_abort > MAX_RETRY);
    n_cmd = timeout_case ? 1 : ((n_abort > MAX_RETRY) ? MAX_RETRY + 1 : n_abort + 1);
    exp_cmd = a_we ? {2'b10, a_addr} : {2'b11, a_addr};
    exp_q.delete();
    got_q.delete();
    repeat (n_cmd) exp_q.push_back(exp_cmd);
    if (!exp_err && a_we) begin
      exp_q.push_back(a_wdata);
      exp_q.push_back(8'h00);
    end
    if (timeout_case)            exp_end = pre_dir + 1 + TIMEOUT;
    else if (n_abort > MAX_RETRY) exp_end = pre_dir + 1 + 4 * (MAX_RETRY + 1);
    else exp_end = pre_dir + 4 * n_abort + (a_we ? 4 + cmd_dly + dat_dly : 5 + cmd_dly);

    ph = (pre_dir > 0) ? PH_HOLD : PH_IDLE;
    hold = pre_dir;
    wait_cnt = 0; end_cyc = -1; busy_low = 0; stray_stp = 0; contention = 0;
    aborts_left = n_abort;
    cmd_seen = 0; dat_seen = 0; ended = 0; got_done = 0; got_err = 0;
    seen_addr = 6'd0; seen_w = 8'h00; seen_we = 1'b0;

    for (cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) begin
        if (done || err) begin
          ended = 1; got_done = done; got_err = err; end_cyc = cyc;
          check_val("busy_end", busy, 0);
          break;
        end
        if (!busy) busy_low++;
      end
      if (stp && ph != PH_STP) stray_stp++;

      nxt = 1'b0;
      data_i = 8'h00;
      case (ph)
        PH_IDLE: begin
          dir = 1'b0;
          if (data_oe && data_o[7] && !cmd_seen) begin
            cmd_seen = 1;
            got_q.push_back(data_o);
            seen_addr = data_o[5:0];
            seen_we = ~data_o[6];
          end
          if (cmd_seen) begin
            if (aborts_left > 0) begin
              aborts_left--;
              dir = 1'b1;
              hold = 2;
              ph = PH_HOLD;
              cmd_seen = 0;
            end else if (wait_cnt >= cmd_dly) begin
              nxt = 1'b1;
              wait_cnt = 0;
              cmd_seen = 0;
              ph = seen_we ? PH_WDATA : PH_RTURN;
            end else begin
              wait_cnt++;
            end
          end
        end
        PH_WDATA: begin
          dir = 1'b0;
          if (!dat_seen) begin
            dat_seen = 1;
            got_q.push_back(data_o);
            seen_w = data_o;
          end
          if (wait_cnt >= dat_dly) begin
            nxt = 1'b1;
            wait_cnt = 0;
            ph = PH_STP;
          end else begin
            wait_cnt++;
          end
        end
        PH_STP: begin
          dir = 1'b0;
          check_val("stp", stp, 1);
          got_q.push_back(data_o);
          phy_reg[seen_addr] = seen_w;
          ph = PH_FIN;
        end
        PH_RTURN: begin
          check_val("rturn_oe", data_oe, 0);
          dir = 1'b1;
          ph = PH_RDATA;
        end
        PH_RDATA: begin
          dir = 1'b1;
          data_i = phy_reg[seen_addr];
          ph = PH_RREL;
        end
        PH_RREL: begin
          dir = 1'b0;
          ph = PH_FIN;
        end
        PH_HOLD: begin
          if (hold > 0) begin
            dir = 1'b1;
            hold--;
          end else begin
            dir = 1'b0;
            ph = PH_IDLE;
          end
        end
        default: dir = 1'b0;
      endcase

      if (cyc == 0) begin
        req = 1'b1; we = a_we; addr = a_addr; wdata = a_wdata;
      end else if (noise && $urandom_range(0, 3) == 0) begin
        req = 1'b1; we = 1'($urandom); addr = 6'($urandom); wdata = 8'($urandom);
      end else begin
        req = 1'b0;
      end
      #1;
      if (dir && data_oe) contention++;

      if (cyc == rst_at) begin
        rstn = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        req = 1'b0; dir = 1'b0; nxt = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end

    req = 1'b0; dir = 1'b0; nxt = 1'b0;
    if (!ended) $display("FAIL budget no done/err within 300 cycles state=%0d", dbg_state);
    check_val("ended", ended, 1);
    check_val("done", got_done, !exp_err);
    check_val("err", got_err, exp_err);
    check_val("latency", end_cyc, exp_end);
    check_val("busy_gap", busy_low, 0);
    check_val("stray_stp", stray_stp, 0);
    check_val("contention", contention, 0);
    check_val("bus_len", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check_val("bus_byte", got_q.pop_front(), exp_q.pop_front());
    if (!exp_err && !a_we) check_val("rdata", rdata, ref_reg[a_addr]);
    if (!exp_err && a_we) ref_reg[a_addr] = a_wdata;
    tick();
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_reg[i] = 8'($urandom);
      phy_reg[i] = ref_reg[i];
    end
    ref_reg[6'h0A] = 8'h5A;
    phy_reg[6'h0A] = 8'h5A;

    rstn = 1'b0; req = 1'b0; we = 1'b0; addr = 6'd0; wdata = 8'h00;
    data_i = 8'h00; dir = 1'b0; nxt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    run_access(1'b1, 6'h04, 8'h45, 0, 0, 0, 0, 1'b0, -1);   // basic write
    run_access(1'b0, 6'h0A, 8'h00, 0, 0, 0, 0, 1'b0, -1);   // basic read, 5A
    run_access(1'b1, 6'h11, 8'h3C, 0, 0, 1, 0, 1'b0, -1);   // one abort, retried
    run_access(1'b1, 6'h12, 8'h77, 100, 0, 0, 0, 1'b0, -1); // PHY silent: timeout
    run_access(1'b1, 6'h15, 8'h99, 0, 0, 0, 3, 1'b0, -1);   // req while dir=1
    run_access(1'b0, 6'h04, 8'h00, 2, 0, 4, 0, 1'b0, -1);   // retries exhausted

    run_access(1'b1, 6'h20, 8'hAB, 0, 10, 0, 0, 1'b0, 3);   // reset during WDATA
    tick();
    rstn = 1'b1;
    tick();
    run_access(1'b0, 6'h04, 8'h00, 0, 0, 0, 0, 1'b0, -1);   // read after reset

    repeat (40) begin
      int ab;
      ab = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 4));
      run_access(1'($urandom_range(0, 1)), 6'($urandom), 8'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), ab,
                 int'($urandom_range(0, 2)), 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
